pci_burst_target: RTL and testbench

- Parametrised PCI-style bus target: claims memory read/write bursts addressed to its window and serves them from an internal byte-writable register file.
- Extends the fixed 10-word single-device model with configurable data width, memory depth, base address and wait states.
- Adds byte enables, end-of-window disconnect (STOP), initiator wait handling and non-claim of foreign addresses.
- Sits behind the bus arbiter alongside the initiator devices. AD tri-stating is done in the parent through ad_out/ad_oe.

---
 rtl/pci_pkg.sv | 28 ++
 rtl/pci_burst_target_if.sv | 25 ++
 rtl/pci_target_mem.sv | 31 +++
 rtl/pci_burst_target.sv | 180 ++++++++++++++++++
 tb/tb_pci_burst_target.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI burst target: bus command codes, the
// sequencer state encoding and a constant-width helper.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_DISC = 3'd3,
        ST_BUSY = 3'd4
    } state_t;

    // Bits needed to index 'value' entries (0 for a single entry).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pci_burst_target_if.sv
// PCI target-side bus bundle; the parent resolves AD tri-stating from
// ad_out/ad_oe.
interface pci_burst_target_if #(
    parameter int DATA_W = 32
);
    logic                  frame_n;
    logic                  irdy_n;
    logic [DATA_W/8-1:0]   cbe_n;
    logic [DATA_W-1:0]     ad_in;
    logic [DATA_W-1:0]     ad_out;
    logic                  ad_oe;
    logic                  trdy_n;
    logic                  devsel_n;
    logic                  stop_n;

    modport master (
        output frame_n, irdy_n, cbe_n, ad_in,
        input  ad_out, ad_oe, trdy_n, devsel_n, stop_n
    );

    modport slave (
        input  frame_n, irdy_n, cbe_n, ad_in,
        output ad_out, ad_oe, trdy_n, devsel_n, stop_n
    );
endinterface

// File: rtl/pci_target_mem.sv
// Word-addressed register file with a byte-lane write port and an
// asynchronous read port. Contents are deliberately not reset.
module pci_target_mem
    import pci_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [clog2(DEPTH)-1:0]       addr,
    input  logic [DATA_W/8-1:0]           be,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata
);
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Byte-lane write: only enabled lanes of the addressed word change
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (be[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/pci_burst_target.sv
// PCI memory-burst target: fast-decode claim of its address window, optional
// initial wait states, byte-enabled writes and STOP at the end of the window.
module pci_burst_target
    import pci_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 16,
    parameter logic [DATA_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    pci_burst_target_if.slave    bus
);
    localparam int                BYTES     = DATA_W / 8;
    localparam int                AW        = clog2(DEPTH);
    localparam int                BSH       = clog2(BYTES);
    localparam logic [DATA_W-1:0] WIN_BYTES = DATA_W'(DEPTH * BYTES);
    localparam logic [AW-1:0]     LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [3:0]        WS_WR     = 4'(WAIT_STATES);
    localparam logic [3:0]        WS_RD     = 4'(WAIT_STATES + 1);

    state_t                state_r;
    logic [AW-1:0]         ptr_r;
    logic [3:0]            cnt_r;
    logic                  is_wr_r;
    logic                  frame_prev_r;
    logic                  trdy_r;
    logic                  devsel_r;
    logic                  stop_r;
    logic                  oe_r;

    logic [3:0]            cmd_s;
    logic                  cmd_rd_s;
    logic                  cmd_wr_s;
    logic [DATA_W:0]       diff_s;
    logic [DATA_W-1:0]     offset_s;
    logic                  hit_s;
    logic [AW-1:0]         start_ptr_s;
    logic                  xfer_s;
    logic                  we_s;
    logic [DATA_W-1:0]     rdata_s;

    // Address decode; the extra borrow bit tells "below the window" apart
    // from a large offset without a signed compare.
    assign cmd_s       = bus.cbe_n[3:0];
    assign cmd_rd_s    = (cmd_s == CMD_MEM_READ);
    assign cmd_wr_s    = (cmd_s == CMD_MEM_WRITE);
    assign diff_s      = {1'b0, bus.ad_in} - {1'b0, BASE_ADDR};
    assign offset_s    = diff_s[DATA_W-1:0];
    assign hit_s       = (cmd_rd_s || cmd_wr_s) && (bus.ad_in[1:0] == 2'b00)
                         && !diff_s[DATA_W] && (offset_s < WIN_BYTES);
    assign start_ptr_s = offset_s[BSH +: AW];

    assign xfer_s = (state_r == ST_DATA) && !bus.irdy_n && !trdy_r;
    assign we_s   = xfer_s && is_wr_r;

    pci_target_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .addr  (ptr_r),
        .be    (~bus.cbe_n),
        .wdata (bus.ad_in),
        .rdata (rdata_s)
    );

    assign bus.ad_out   = oe_r ? rdata_s : {DATA_W{1'b0}};
    assign bus.ad_oe    = oe_r;
    assign bus.trdy_n   = trdy_r;
    assign bus.devsel_n = devsel_r;
    assign bus.stop_n   = stop_r;

    // Transaction sequencer; every bus control output is a register here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            ptr_r        <= {AW{1'b0}};
            cnt_r        <= 4'd0;
            is_wr_r      <= 1'b0;
            frame_prev_r <= 1'b1;
            trdy_r       <= 1'b1;
            devsel_r     <= 1'b1;
            stop_r       <= 1'b1;
            oe_r         <= 1'b0;
        end else begin
            frame_prev_r <= bus.frame_n;
            case (state_r)
                ST_IDLE: begin
                    if (!bus.frame_n && frame_prev_r) begin
                        is_wr_r <= cmd_wr_s;
                        if (hit_s) begin
                            devsel_r <= 1'b0;
                            ptr_r    <= start_ptr_s;
                            if (cmd_wr_s) begin
                                if (WAIT_STATES == 0) begin
                                    trdy_r  <= 1'b0;
                                    state_r <= ST_DATA;
                                end else begin
                                    cnt_r   <= WS_WR;
                                    state_r <= ST_WAIT;
                                end
                            end else begin
                                // Read needs one extra cycle for AD turnaround
                                oe_r    <= 1'b1;
                                cnt_r   <= WS_RD;
                                state_r <= ST_WAIT;
                            end
                        end else begin
                            state_r <= ST_BUSY;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.frame_n && bus.irdy_n) begin
                        trdy_r   <= 1'b1;
                        devsel_r <= 1'b1;
                        stop_r   <= 1'b1;
                        oe_r     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else if (cnt_r == 4'd1) begin
                        cnt_r   <= 4'd0;
                        trdy_r  <= 1'b0;
                        state_r <= ST_DATA;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DATA: begin
                    if (bus.frame_n && bus.irdy_n) begin
                        trdy_r   <= 1'b1;
                        devsel_r <= 1'b1;
                        stop_r   <= 1'b1;
                        oe_r     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else if (xfer_s) begin
                        if (ptr_r != LAST_PTR) begin
                            ptr_r <= ptr_r + AW'(1'b1);
                        end
                        if (bus.frame_n) begin
                            trdy_r   <= 1'b1;
                            devsel_r <= 1'b1;
                            oe_r     <= 1'b0;
                            state_r  <= ST_IDLE;
                        end else if (ptr_r == LAST_PTR) begin
                            // Window exhausted: disconnect rather than wrap
                            trdy_r  <= 1'b1;
                            stop_r  <= 1'b0;
                            state_r <= ST_DISC;
                        end
                    end
                end
                ST_DISC: begin
                    if (bus.frame_n) begin
                        trdy_r   <= 1'b1;
                        devsel_r <= 1'b1;
                        stop_r   <= 1'b1;
                        oe_r     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (bus.frame_n && bus.irdy_n) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    trdy_r   <= 1'b1;
                    devsel_r <= 1'b1;
                    stop_r   <= 1'b1;
                    oe_r     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_burst_target.sv
// Directed plus randomized bursts against two targets sharing one bus
// (different windows, 0 and 2 wait states), checked against a word-array model.
module tb_pci_burst_target;
    import pci_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE0 = 32'h0000_0100;
    localparam logic [31:0] BASE1 = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_n;
    logic        irdy_n;
    logic [3:0]  cbe_n;
    logic [31:0] ad_in;
    bit          sel_r;

    int errors = 0;
    int checks = 0;

    logic [31:0] m0 [DEPTH];
    logic [31:0] m1 [DEPTH];
    logic [31:0] wd_q [$];
    logic [3:0]  wbe_q [$];

    always #5 clk = ~clk;

    pci_burst_target_if #(.DATA_W(32)) bus0 ();
    pci_burst_target_if #(.DATA_W(32)) bus1 ();

    assign bus0.frame_n = frame_n;
    assign bus0.irdy_n  = irdy_n;
    assign bus0.cbe_n   = cbe_n;
    assign bus0.ad_in   = ad_in;
    assign bus1.frame_n = frame_n;
    assign bus1.irdy_n  = irdy_n;
    assign bus1.cbe_n   = cbe_n;
    assign bus1.ad_in   = ad_in;

    pci_burst_target #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE0), .WAIT_STATES(0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    pci_burst_target #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE1), .WAIT_STATES(2))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    wire        trdy_s = sel_r ? bus1.trdy_n   : bus0.trdy_n;
    wire        dsel_s = sel_r ? bus1.devsel_n : bus0.devsel_n;
    wire        stop_s = sel_r ? bus1.stop_n   : bus0.stop_n;
    wire        oe_s   = sel_r ? bus1.ad_oe    : bus0.ad_oe;
    wire [31:0] ado_s  = sel_r ? bus1.ad_out   : bus0.ad_out;

    // {devsel_n, trdy_n, stop_n, ad_oe}; an idle target shows 4'b1110
    function automatic logic [3:0] stat(input bit s);
        if (s) return {bus1.devsel_n, bus1.trdy_n, bus1.stop_n, bus1.ad_oe};
        else   return {bus0.devsel_n, bus0.trdy_n, bus0.stop_n, bus0.ad_oe};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input bit s, input int w);
        return s ? m1[w] : m0[w];
    endfunction

    task automatic model_write(input bit s, input int w, input logic [31:0] d, input logic [3:0] be_n);
        logic [31:0] cur;
        cur = s ? m1[w] : m0[w];
        for (int b = 0; b < 4; b++) begin
            if (!be_n[b]) cur[8*b +: 8] = d[8*b +: 8];
        end
        if (s) m1[w] = cur;
        else   m0[w] = cur;
    endtask

    // One master burst; write data/enables come from wd_q/wbe_q.
    task automatic burst(input bit s, input bit wr, input int word, input int n, input int stall_pct);
        int  k, cyc, first_trdy, exp_x, ws;
        bit  stopped, stall;
        sel_r = s;
        ws    = s ? 2 : 0;
        exp_x = (n < DEPTH - word) ? n : DEPTH - word;
        frame_n = 1'b0;
        irdy_n  = 1'b1;
        cbe_n   = wr ? CMD_MEM_WRITE : CMD_MEM_READ;
        ad_in   = (s ? BASE1 : BASE0) + 32'(word * 4);
        @(negedge clk);
        check("devsel_fast", 32'(dsel_s), 32'd0);
        check("ad_oe_addr", 32'(oe_s), wr ? 32'd0 : 32'd1);
        k = 0; cyc = 1; first_trdy = 0; stopped = 1'b0;
        while (k < n && !stopped && cyc < 64) begin
            if (!stop_s) begin
                stopped = 1'b1;
                check("disc_signals", {29'd0, dsel_s, trdy_s, stop_s}, 32'd2);
            end else begin
                if (!trdy_s && first_trdy == 0) first_trdy = cyc;
                stall   = ($urandom_range(99) < 32'(stall_pct));
                irdy_n  = stall;
                frame_n = (k == n - 1 && !stall) ? 1'b1 : 1'b0;
                if (wr) begin
                    cbe_n = wbe_q[k];
                    ad_in = wd_q[k];
                end else begin
                    cbe_n = 4'b0000;
                    ad_in = $urandom;
                    if (!trdy_s) check("rd_data", ado_s, model_read(s, word + k));
                end
                if (!trdy_s && !stall) begin
                    if (wr) model_write(s, word + k, wd_q[k], wbe_q[k]);
                    k++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("no_timeout", 32'(cyc < 64), 32'd1);
        check("xfer_count", 32'(k), 32'(exp_x));
        check("stop_seen", 32'(stopped), 32'(n > DEPTH - word));
        check("first_trdy", 32'(first_trdy), 32'(ws + 1 + (wr ? 0 : 1)));
        if (stopped) begin
            frame_n = 1'b1;
            irdy_n  = 1'b0;
            @(negedge clk);
        end
        check("released", {28'd0, stat(s)}, 32'hE);
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        @(negedge clk);
        check("idle_both", {24'd0, stat(0), stat(1)}, 32'hEE);
    endtask

    // Address nobody claims; both targets must stay silent.
    task automatic miss(input string tag, input logic [31:0] addr, input logic [3:0] cmd);
        frame_n = 1'b0;
        irdy_n  = 1'b1;
        cbe_n   = cmd;
        ad_in   = addr;
        @(negedge clk);
        check(tag, {24'd0, stat(0), stat(1)}, 32'hEE);
        frame_n = 1'b1;
        irdy_n  = 1'b0;
        cbe_n   = 4'b0000;
        repeat (4) begin
            @(negedge clk);
            check(tag, {24'd0, stat(0), stat(1)}, 32'hEE);
        end
        irdy_n = 1'b1;
        @(negedge clk);
        check(tag, {24'd0, stat(0), stat(1)}, 32'hEE);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int wr, word, n;
        reset   = 1'b1;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        cbe_n   = 4'hF;
        ad_in   = 32'd0;
        sel_r   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {24'd0, stat(0), stat(1)}, 32'hEE);
        check("reset_ad_out", bus0.ad_out, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Four full-word writes then read-back
        wd_q  = '{32'h11, 32'h22, 32'h33, 32'h44};
        wbe_q = '{4'h0, 4'h0, 4'h0, 4'h0};
        burst(1'b0, 1'b1, 0, 4, 0);
        burst(1'b0, 1'b0, 0, 4, 0);

        // Fill the rest of the window so every word has a known value
        wd_q.delete();
        wbe_q.delete();
        for (int i = 0; i < 12; i++) begin
            wd_q.push_back($urandom);
            wbe_q.push_back(4'h0);
        end
        burst(1'b0, 1'b1, 4, 12, 0);

        // Partial byte-enable write over a known word
        wd_q  = '{32'h1234_5678};
        wbe_q = '{4'h0};
        burst(1'b0, 1'b1, 5, 1, 0);
        wd_q  = '{32'hAABB_CCDD};
        wbe_q = '{4'b1100};
        burst(1'b0, 1'b1, 5, 1, 0);
        burst(1'b0, 1'b0, 5, 1, 0);

        // Two wait states on the second target
        wd_q  = '{32'hCAFE_0003};
        wbe_q = '{4'h0};
        burst(1'b1, 1'b1, 3, 1, 0);
        burst(1'b1, 1'b0, 3, 1, 0);

        // Burst running off the end of the window, then full read-back
        wd_q.delete();
        wbe_q.delete();
        for (int i = 0; i < 6; i++) begin
            wd_q.push_back($urandom);
            wbe_q.push_back(4'h0);
        end
        burst(1'b0, 1'b1, DEPTH - 2, 6, 0);
        burst(1'b0, 1'b0, 0, DEPTH, 0);

        miss("miss_range", BASE0 + 32'd64, CMD_MEM_WRITE);
        miss("miss_cmd", BASE0, 4'b0010);
        miss("miss_align", BASE0 + 32'd1, CMD_MEM_READ);

        // Read stalled by the initiator, then reset mid-burst
        sel_r   = 1'b0;
        frame_n = 1'b0;
        irdy_n  = 1'b1;
        cbe_n   = CMD_MEM_READ;
        ad_in   = BASE0 + 32'd8;
        @(negedge clk);
        irdy_n = 1'b0;
        cbe_n  = 4'b0000;
        t = 0;
        while (trdy_s && t < 8) begin
            @(negedge clk);
            t++;
        end
        check("stall_trdy", 32'(trdy_s), 32'd0);
        check("stall_w2", ado_s, m0[2]);
        @(negedge clk);
        check("stall_w3", ado_s, m0[3]);
        irdy_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_hold", ado_s, m0[3]);
        end
        irdy_n = 1'b0;
        @(negedge clk);
        check("stall_resume", ado_s, m0[4]);
        #2 reset = 1'b1;
        #1;
        check("async_reset", {24'd0, stat(0), stat(1)}, 32'hEE);
        check("async_reset_ad", bus0.ad_out, 32'd0);
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        burst(1'b0, 1'b0, 0, 4, 0);

        // Randomized traffic with initiator stalls
        for (int it = 0; it < 24; it++) begin
            wr   = int'($urandom_range(1));
            word = int'($urandom_range(DEPTH - 1));
            n    = int'($urandom_range(6, 1));
            wd_q.delete();
            wbe_q.delete();
            for (int i = 0; i < n; i++) begin
                wd_q.push_back($urandom);
                wbe_q.push_back(4'($urandom_range(15)));
            end
            burst(1'b0, wr[0], word, n, 30);
        end
        burst(1'b0, 1'b0, 0, DEPTH, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
